// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared constants, lock state type and one-hot encoder for rr_mux.
package rr_mux_pkg;

  // Output buffer geometry: 2 entries, 1-bit pointers, count 0..2.
  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned PTR_W     = 1;

  // Upper bound on port count so the lock index width is fixed in the package.
  localparam int unsigned MAX_PORTS = 256;
  localparam int unsigned IDX_W     = $clog2(MAX_PORTS);

  // Packet lock: valid flag plus index of the port being held.
  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } lock_t;

  // One-hot to binary; OR-based so it stays a flat encoder.
  function automatic logic [IDX_W-1:0] oh2bin(input logic [MAX_PORTS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_mux_buf.sv
// rr_mux_buf: 2-entry circular output FIFO, no bypass, pointers wrap 1->0.
module rr_mux_buf
  import rr_mux_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;

  // Pointer and occupancy next-state.
  always_comb begin
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset discards any buffered beats.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Payload storage needs no reset: it is only read while count != 0.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign full_o  = (cnt_q == CNT_W'(BUF_DEPTH));
  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/rr_mux.sv
// rr_mux: W-port valid/ready fan-in driven by an external round-robin arbiter.
// Optional packet lock (holds one port until its last beat): RR_MUX_PKT_LOCK_EN.
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter int unsigned W      = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                arst,
  input  logic [W-1:0]        i_valid,
  input  logic [W*DATA_W-1:0] i_data,
`ifdef RR_MUX_PKT_LOCK_EN
  input  logic [W-1:0]        i_last,
`endif
  output logic [W-1:0]        o_ready,
  output logic [W-1:0]        o_arb_req,
  input  logic [W-1:0]        i_arb_gnt,
  output logic                o_arb_ack,
  output logic                o_valid,
  output logic [DATA_W-1:0]   o_data,
  input  logic                i_ready
);

  logic              full;
  logic              accept_ok;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] mux_data;

  // Acceptance depends only on registered occupancy, never on i_ready.
  assign accept_ok = ~full;
  assign o_ready   = i_arb_gnt & i_valid & {W{accept_ok}};
  assign push      = |o_ready;
  assign pop       = o_valid & i_ready;

  // AND-OR mux of the granted port's payload.
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < W; k++) begin
      mux_data = mux_data | (i_data[k*DATA_W +: DATA_W] & {DATA_W{o_ready[k]}});
    end
  end

`ifdef RR_MUX_PKT_LOCK_EN
  lock_t        lock_q, lock_d;
  logic [W-1:0] lock_mask;
  logic         last_sel;

  // Request/ack with packet lock; lock releases on the beat carrying last.
  always_comb begin
    lock_d    = lock_q;
    lock_mask = W'(1) << lock_q.idx;
    last_sel  = |(o_ready & i_last);
    o_arb_req = '0;
    o_arb_ack = push & last_sel;
    if (accept_ok) o_arb_req = lock_q.vld ? (i_valid & lock_mask) : i_valid;
    if (push) begin
      lock_d.vld = ~last_sel;
      lock_d.idx = oh2bin(MAX_PORTS'(o_ready));
    end
  end

  // Lock register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) lock_q <= '0;
    else      lock_q <= lock_d;
  end
`else
  // Per-beat arbitration: every accepted beat advances the arbiter.
  always_comb begin
    o_arb_req = '0;
    o_arb_ack = push;
    if (accept_ok) o_arb_req = i_valid;
  end
`endif

  rr_mux_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk     (clk),
    .arst    (arst),
    .push_i  (push),
    .data_i  (mux_data),
    .pop_i   (pop),
    .full_o  (full),
    .valid_o (o_valid),
    .data_o  (o_data)
  );

  // The arbiter must return exactly one grant whenever something is requested.
  gnt_onehot_a : assert property (@(posedge clk) disable iff (arst)
    (|o_arb_req) |-> $onehot(i_arb_gnt));

endmodule

// File: tb/tb_rr_mux.sv
// tb_rr_mux: directed scoreboard bench for rr_mux with a round-robin arbiter model.
module tb_rr_mux;

  localparam int unsigned W      = 4;
  localparam int unsigned DATA_W = 32;

  logic                clk = 1'b0;
  logic                arst;
  logic [W-1:0]        i_valid;
  logic [W*DATA_W-1:0] i_data;
  logic [W-1:0]        o_ready;
  logic [W-1:0]        o_arb_req;
  logic [W-1:0]        i_arb_gnt;
  logic                o_arb_ack;
  logic                o_valid;
  logic [DATA_W-1:0]   o_data;
  logic                i_ready;
`ifdef RR_MUX_PKT_LOCK_EN
  logic [W-1:0]        i_last;
`endif

  logic [DATA_W:0]     src [W][$];   // {last, data} per beat
  logic [DATA_W-1:0]   sb [$];
  logic                rdy;
  logic [1:0]          arb_ptr;
  int                  tests_run    = 0;
  int                  tests_failed = 0;

  always #5 clk = ~clk;

  rr_mux #(.W(W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .arst      (arst),
    .i_valid   (i_valid),
    .i_data    (i_data),
`ifdef RR_MUX_PKT_LOCK_EN
    .i_last    (i_last),
`endif
    .o_ready   (o_ready),
    .o_arb_req (o_arb_req),
    .i_arb_gnt (i_arb_gnt),
    .o_arb_ack (o_arb_ack),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .i_ready   (i_ready)
  );

  // Round-robin arbiter model: first requester at or after the pointer wins.
  always_comb begin
    i_arb_gnt = '0;
    for (int n = W - 1; n >= 0; n--) begin
      if (o_arb_req[(int'(arb_ptr) + n) % W]) begin
        i_arb_gnt = '0;
        i_arb_gnt[(int'(arb_ptr) + n) % W] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) arb_ptr <= '0;
    else if (o_arb_ack) begin
      for (int n = 0; n < W; n++) begin
        if (i_arb_gnt[n]) arb_ptr <= 2'((n + 1) % W);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: drive sources at negedge, settle, retire accepted source beats.
  task automatic step();
    logic [DATA_W:0] beat;
    @(negedge clk);
    i_ready = rdy;
    for (int k = 0; k < W; k++) begin
      i_valid[k] = (src[k].size() != 0);
      i_data[k*DATA_W +: DATA_W] = i_valid[k] ? src[k][0][DATA_W-1:0] : '0;
`ifdef RR_MUX_PKT_LOCK_EN
      i_last[k] = i_valid[k] ? src[k][0][DATA_W] : 1'b0;
`endif
    end
    #1;
    for (int k = 0; k < W; k++) begin
      if (o_ready[k] && src[k].size() != 0) beat = src[k].pop_front();
    end
  endtask

  task automatic reset_dut();
    arst    = 1'b1;
    rdy     = 1'b0;
    i_ready = 1'b0;
    i_valid = '0;
    i_data  = '0;
`ifdef RR_MUX_PKT_LOCK_EN
    i_last  = '0;
`endif
    for (int k = 0; k < W; k++) src[k].delete();
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
  endtask

  // Scoreboard monitor: every output handshake pops and compares one beat.
  initial begin
    logic [DATA_W-1:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (!arst && o_valid && i_ready) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_unexpected: got 0x%0h, expected no output", o_data);
        end else begin
          exp = sb.pop_front();
          if (o_data !== exp) begin
            tests_failed++;
            $display("FAIL sb_data: got 0x%0h, expected 0x%0h", o_data, exp);
          end
        end
      end
    end
  end

  initial begin
    logic [W-1:0] exp_rdy [5];

    // Reset state
    arst    = 1'b1;
    rdy     = 1'b0;
    i_ready = 1'b0;
    i_valid = '0;
    i_data  = '0;
`ifdef RR_MUX_PKT_LOCK_EN
    i_last  = '0;
`endif
    #3;
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_ready", 32'(o_ready), 32'd0);
    chk("rst_o_arb_req", 32'(o_arb_req), 32'd0);
    chk("rst_o_arb_ack", 32'(o_arb_ack), 32'd0);
    reset_dut();

    // 1: single push, visible next cycle
    rdy = 1'b1;
    src[2].push_back({1'b1, 32'hA5});
    sb.push_back(32'hA5);
    step();
    chk("t1_req", 32'(o_arb_req), 32'h4);
    chk("t1_ready", 32'(o_ready), 32'h4);
    chk("t1_ack", 32'(o_arb_ack), 32'd1);
    chk("t1_no_bypass", 32'(o_valid), 32'd0);
    step();
    chk("t1_valid", 32'(o_valid), 32'd1);
    chk("t1_data", o_data, 32'hA5);

    // 2+4: stall until full, hold, single pop, refill, drain
    reset_dut();
    for (int k = 0; k < W; k++) begin
      src[k].push_back({1'b1, 32'h20 + 32'(k)});
      sb.push_back(32'h20 + 32'(k));
    end
    step();
    chk("t2_ready0", 32'(o_ready), 32'h1);
    step();
    chk("t2_ready1", 32'(o_ready), 32'h2);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("t2_full_req", 32'(o_arb_req), 32'h0);
      chk("t2_full_ready", 32'(o_ready), 32'h0);
      chk("t2_full_ack", 32'(o_arb_ack), 32'd0);
      chk("t2_full_data", o_data, 32'h20);
    end
    rdy = 1'b1;
    step();
    chk("t4_pop_no_accept", 32'(o_ready), 32'h0);
    rdy = 1'b0;
    step();
    chk("t4_resume_req", 32'(o_arb_req), 32'hC);
    chk("t4_resume_ready", 32'(o_ready), 32'h4);
    chk("t4_rd_wrap_data", o_data, 32'h21);
    step();
    chk("t4_full_again", 32'(o_arb_req), 32'h0);
    chk("t4_hold_data", o_data, 32'h21);
    rdy = 1'b1;
    repeat (4) step();
    chk("t4_drained", 32'(sb.size()), 32'd0);

    // 3: all ports valid, downstream always ready
    reset_dut();
    rdy = 1'b1;
    src[0].push_back({1'b1, 32'h30});
    src[1].push_back({1'b1, 32'h31});
    src[2].push_back({1'b1, 32'h32});
    src[3].push_back({1'b1, 32'h33});
    src[0].push_back({1'b1, 32'h34});
    for (int i = 0; i < 5; i++) sb.push_back(32'h30 + 32'(i));
    exp_rdy = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_grant", 32'(o_ready), 32'(exp_rdy[i]));
      chk("t3_ack", 32'(o_arb_ack), 32'd1);
      if (i > 0) chk("t3_no_bubble", 32'(o_valid), 32'd1);
    end
    step();
    chk("t3_last_valid", 32'(o_valid), 32'd1);
    step();
    chk("t3_empty", 32'(o_valid), 32'd0);
    chk("t3_drained", 32'(sb.size()), 32'd0);

    // 5: async reset with a full buffer
    reset_dut();
    src[0].push_back({1'b1, 32'h50});
    src[0].push_back({1'b1, 32'h51});
    repeat (3) step();
    chk("t5_full", 32'(o_arb_req), 32'h0);
    chk("t5_valid_before", 32'(o_valid), 32'd1);
    #2;
    arst = 1'b1;
    #1;
    chk("t5_async_valid", 32'(o_valid), 32'd0);
    chk("t5_async_ready", 32'(o_ready), 32'd0);
    reset_dut();
    rdy = 1'b1;
    src[1].push_back({1'b1, 32'h5F});
    sb.push_back(32'h5F);
    step();
    step();
    chk("t5_fresh_valid", 32'(o_valid), 32'd1);
    chk("t5_fresh_data", o_data, 32'h5F);
    step();
    chk("t5_no_stale", 32'(o_valid), 32'd0);

`ifdef RR_MUX_PKT_LOCK_EN
    // 6: 3-beat packet on port 1 holds off port 2
    reset_dut();
    rdy = 1'b1;
    src[1].push_back({1'b0, 32'h61});
    src[1].push_back({1'b0, 32'h62});
    src[1].push_back({1'b1, 32'h63});
    src[2].push_back({1'b1, 32'h70});
    sb.push_back(32'h61);
    sb.push_back(32'h62);
    sb.push_back(32'h63);
    sb.push_back(32'h70);
    step();
    chk("t6_b1_ready", 32'(o_ready), 32'h2);
    chk("t6_b1_ack", 32'(o_arb_ack), 32'd0);
    step();
    chk("t6_locked_req", 32'(o_arb_req), 32'h2);
    chk("t6_b2_ack", 32'(o_arb_ack), 32'd0);
    step();
    chk("t6_b3_ready", 32'(o_ready), 32'h2);
    chk("t6_b3_ack", 32'(o_arb_ack), 32'd1);
    step();
    chk("t6_p2_ready", 32'(o_ready), 32'h4);
    chk("t6_p2_ack", 32'(o_arb_ack), 32'd1);
    repeat (3) step();
    chk("t6_drained", 32'(sb.size()), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
